// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side bus for the unified memory port arbiter
interface mem_port_arbiter_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19
);
  // Instruction fetch requester (reads only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  // Load/store requester
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;

  // Debug/loader requester
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;

  // Shared read data, qualified by one of the *_rvalid pulses
  logic [DATA_W-1:0] rdata;

  // Memory macro side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  // Requesters plus memory macro side
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way arbiter for the single-port unified memory with dbg starvation guard
module mem_port_arbiter #(
  parameter int DATA_W   = 19,
  parameter int ADDR_W   = 19,
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 8
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  // WAIT counts down from READ_LAT-1 so the capture lands on the last WAIT cycle
  localparam logic [2:0]        LAT_LAST = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LS, OWN_DBG} owner_t;

  state_t            state;
  owner_t            owner;
  logic [2:0]        lat_cnt;
  logic [WAIT_W-1:0] dbg_wait;

  logic              if_gnt_q;
  logic              ls_gnt_q;
  logic              dbg_gnt_q;
  logic              if_rvalid_q;
  logic              ls_rvalid_q;
  logic              dbg_rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;

  logic              any_req;
  logic              dbg_force;
  owner_t            win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Pick the winner among live requests: ls > if > dbg, unless dbg has waited MAX_WAIT times
  always_comb begin
    any_req   = bus.if_req | bus.ls_req | bus.dbg_req;
    dbg_force = bus.dbg_req && (dbg_wait == WAIT_SAT);
    win       = OWN_DBG;
    win_we    = bus.dbg_we;
    win_addr  = bus.dbg_addr;
    win_wdata = bus.dbg_wdata;
    if (!dbg_force) begin
      if (bus.ls_req) begin
        win       = OWN_LS;
        win_we    = bus.ls_we;
        win_addr  = bus.ls_addr;
        win_wdata = bus.ls_wdata;
      end else if (bus.if_req) begin
        win       = OWN_IF;
        win_we    = 1'b0;
        win_addr  = bus.if_addr;
        win_wdata = '0;
      end
    end
  end

  // Access sequencer: arbitrate in IDLE, strobe memory in ISSUE, wait out read latency, return data in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      lat_cnt      <= '0;
      dbg_wait     <= '0;
      if_gnt_q     <= 1'b0;
      ls_gnt_q     <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that owns them raises them for one cycle
      if_gnt_q     <= 1'b0;
      ls_gnt_q     <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ISSUE;
            busy_q      <= 1'b1;
            owner       <= win;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win_we;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            if_gnt_q    <= (win == OWN_IF);
            ls_gnt_q    <= (win == OWN_LS);
            dbg_gnt_q   <= (win == OWN_DBG);
          end else begin
            busy_q <= 1'b0;
          end
          // dbg_req high implies any_req, so a non-dbg winner here means dbg lost this round
          if (!bus.dbg_req || (win == OWN_DBG)) begin
            dbg_wait <= '0;
          end else if (dbg_wait != WAIT_SAT) begin
            dbg_wait <= dbg_wait + 1'b1;
          end
        end

        ISSUE: begin
          if (mem_we_q) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT_LAST;
          end
        end

        WAIT: begin
          if (lat_cnt == 3'd0) begin
            state        <= RESP;
            rdata_q      <= bus.mem_rdata;
            if_rvalid_q  <= (owner == OWN_IF);
            ls_rvalid_q  <= (owner == OWN_LS);
            dbg_rvalid_q <= (owner == OWN_DBG);
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt     = if_gnt_q;
  assign bus.ls_gnt     = ls_gnt_q;
  assign bus.dbg_gnt    = dbg_gnt_q;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.ls_rvalid  = ls_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;

endmodule
